// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
//
// Row-based pattern sequencer. Each rising edge of the song tick steps one row
// through an external synchronous note ROM and updates the per-channel note
// numbers, gates and trigger strobes that drive the voice/envelope stages.
//
// Per-channel note codes in a ROM row:
//   0      hold      note and gate unchanged
//   1      off       gate dropped, note kept
//   >= 2   note-on   note updated; gate rises with a one-cycle trig. If the
//                    gate was already high and RETRIG_GAP > 0, the gate is
//                    first held low for RETRIG_GAP cycles so the envelope
//                    sees a fresh attack.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   run        level: 1 = play, 0 = stop and rewind to row 0
//   tick       raw song tick, synchronous to clk; rising edge advances a row
//   rom_addr   row address to the note ROM (registered, = row pointer)
//   rom_data   row data, valid one clk after rom_addr; channel c at
//              [c*NOTE_BITS +: NOTE_BITS]
//   note       current note number per channel, same packing as rom_data
//   gate       per-channel gate to the envelope generators
//   trig       one-cycle pulse per channel, coincident with gate rising
//   row        index of the most recently applied row
//   bar_start  one-cycle pulse when the applied row starts a bar
// -----------------------------------------------------------------------------
module song_sequencer #(
   parameter  int CHANNELS     = 3,
   parameter  int NOTE_BITS    = 7,
   parameter  int ROWS_PER_BAR = 8,
   parameter  int NUM_BARS     = 4,
   parameter  int RETRIG_GAP   = 16,
   localparam int TOTAL_ROWS   = ROWS_PER_BAR * NUM_BARS,
   localparam int ADDR_BITS    = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          run,
   input  logic                          tick,
   output logic [ADDR_BITS-1:0]          rom_addr,
   input  logic [CHANNELS*NOTE_BITS-1:0] rom_data,
   output logic [CHANNELS*NOTE_BITS-1:0] note,
   output logic [CHANNELS-1:0]           gate,
   output logic [CHANNELS-1:0]           trig,
   output logic [ADDR_BITS-1:0]          row,
   output logic                          bar_start
);

   localparam int GAP_BITS = (RETRIG_GAP > 1) ? $clog2(RETRIG_GAP) : 1;
   localparam bit HAS_GAP  = (RETRIG_GAP > 0);

   // Gap counter runs 0 .. RETRIG_GAP-1 while in GAP; the last value is the
   // edge at which retriggered gates come back up.
   localparam logic [GAP_BITS-1:0]  GAP_LAST = GAP_BITS'((RETRIG_GAP > 0) ? RETRIG_GAP - 1 : 0);
   localparam logic [ADDR_BITS-1:0] LAST_ROW = ADDR_BITS'(TOTAL_ROWS - 1);
   localparam logic [NOTE_BITS-1:0] CODE_OFF = NOTE_BITS'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      APPLY = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t                        state, state_n;
   logic [ADDR_BITS-1:0]          row_ptr, row_ptr_n;
   logic                          pending, pending_n;
   logic [GAP_BITS-1:0]           gap_cnt, gap_cnt_n;
   logic [CHANNELS-1:0]           retrig_mask, retrig_mask_n;
   logic                          tick_q;
   logic                          tick_rise;

   logic [CHANNELS*NOTE_BITS-1:0] note_n;
   logic [CHANNELS-1:0]           gate_n;
   logic [CHANNELS-1:0]           trig_n;
   logic [ADDR_BITS-1:0]          row_n;
   logic                          bar_start_n;

   logic [NOTE_BITS-1:0]          row_code [CHANNELS];
   logic [CHANNELS-1:0]           retrig_hit;

   assign tick_rise = tick & ~tick_q;
   assign rom_addr  = row_ptr;

   // Unpack the ROM row and flag channels that need a gap before re-gating:
   // note-on arriving while that channel's gate is already high.
   always_comb begin
      retrig_hit = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         row_code[c]   = rom_data[c*NOTE_BITS +: NOTE_BITS];
         retrig_hit[c] = HAS_GAP && (row_code[c] > CODE_OFF) && gate[c];
      end
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         row_ptr     <= '0;
         pending     <= 1'b0;
         gap_cnt     <= '0;
         retrig_mask <= '0;
         tick_q      <= 1'b0;
         note        <= '0;
         gate        <= '0;
         trig        <= '0;
         row         <= '0;
         bar_start   <= 1'b0;
      end else begin
         state       <= state_n;
         row_ptr     <= row_ptr_n;
         pending     <= pending_n;
         gap_cnt     <= gap_cnt_n;
         retrig_mask <= retrig_mask_n;
         tick_q      <= tick;
         note        <= note_n;
         gate        <= gate_n;
         trig        <= trig_n;
         row         <= row_n;
         bar_start   <= bar_start_n;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_n       = state;
      row_ptr_n     = row_ptr;
      pending_n     = pending;
      gap_cnt_n     = gap_cnt;
      retrig_mask_n = retrig_mask;
      note_n        = note;
      gate_n        = gate;
      trig_n        = '0;
      row_n         = row;
      bar_start_n   = 1'b0;

      if (!run) begin
         // Stop and rewind from any state; note and row keep their last value.
         state_n       = IDLE;
         row_ptr_n     = '0;
         pending_n     = 1'b0;
         gap_cnt_n     = '0;
         retrig_mask_n = '0;
         gate_n        = '0;
      end else begin
         // A tick arriving while a row is in flight is remembered once; any
         // further ticks before it is serviced are lost.
         if (tick_rise && (state != IDLE)) begin
            pending_n = 1'b1;
         end

         case (state)
            IDLE: begin
               if (tick_rise || pending) begin
                  state_n   = WAIT;
                  pending_n = 1'b0;
               end
            end

            // rom_addr has been stable since IDLE; this cycle covers the
            // ROM's one-clock read latency.
            WAIT: begin
               state_n = APPLY;
            end

            APPLY: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  if (row_code[c] > CODE_OFF) begin
                     note_n[c*NOTE_BITS +: NOTE_BITS] = row_code[c];
                     if (retrig_hit[c]) begin
                        gate_n[c] = 1'b0;
                     end else begin
                        gate_n[c] = 1'b1;
                        trig_n[c] = 1'b1;
                     end
                  end else if (row_code[c] == CODE_OFF) begin
                     gate_n[c] = 1'b0;
                  end
               end

               row_n       = row_ptr;
               row_ptr_n   = (row_ptr == LAST_ROW) ? '0 : row_ptr + 1'b1;
               bar_start_n = ((int'(row_ptr) % ROWS_PER_BAR) == 0);

               retrig_mask_n = retrig_hit;
               gap_cnt_n     = '0;
               state_n       = (|retrig_hit) ? GAP : IDLE;
            end

            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gate_n        = gate | retrig_mask;
                  trig_n        = retrig_mask;
                  retrig_mask_n = '0;
                  gap_cnt_n     = '0;
                  state_n       = IDLE;
               end else begin
                  gap_cnt_n = gap_cnt + 1'b1;
               end
            end

            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_sequencer
//
// Directed/random bench for song_sequencer with RETRIG_GAP = 4. The note ROM
// lives in the bench as an array with a one-clock registered read. A per-row
// event model (note/gate arrays, row pointer) predicts the outputs of every
// serviced row and the timing of the retrigger gap.
//
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_song_sequencer;

   localparam int CH    = 3;
   localparam int NB    = 7;
   localparam int RPB   = 8;
   localparam int NBARS = 4;
   localparam int GAPN  = 4;
   localparam int ROWS  = RPB * NBARS;
   localparam int AB    = 5;
   localparam int DW    = CH * NB;

   // ---------------------------------------------------------------- clock/reset
   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          tick;
   logic [AB-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] note;
   logic [CH-1:0] gate;
   logic [CH-1:0] trig;
   logic [AB-1:0] row;
   logic          bar_start;

   always #5 clk = ~clk;

   song_sequencer #(
      .CHANNELS    (CH),
      .NOTE_BITS   (NB),
      .ROWS_PER_BAR(RPB),
      .NUM_BARS    (NBARS),
      .RETRIG_GAP  (GAPN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .tick     (tick),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .note     (note),
      .gate     (gate),
      .trig     (trig),
      .row      (row),
      .bar_start(bar_start)
   );

   // Synchronous note ROM
   logic [DW-1:0] rom_mem [ROWS];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   // ---------------------------------------------------------------- model state
   int            m_note [CH];
   logic [CH-1:0] m_gate;
   int            m_ptr;
   int            m_row;

   int            n_cmp = 0;
   int            n_bad = 0;

   logic          tick_sched [$];
   logic [CH-1:0] retr;
   int            p;

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pack_note();
      logic [DW-1:0] v;
      v = '0;
      for (int c = 0; c < CH; c++) v[c*NB +: NB] = m_note[c][NB-1:0];
      return v;
   endfunction

   function automatic logic [NB-1:0] rand_code();
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) return NB'(0);
      if (r == 1) return NB'(1);
      return NB'($urandom_range(2, 127));
   endfunction

   // One clock step; the tick level follows the schedule queue, else low.
   task automatic nstep();
      @(negedge clk);
      if (tick_sched.size() > 0) tick = tick_sched.pop_front();
      else tick = 1'b0;
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) m_note[c] = 0;
      m_gate = '0;
      m_ptr  = 0;
      m_row  = 0;
   endtask

   // Steps wait_n cycles with outputs held, then one cycle to the point where
   // the serviced row's outputs must appear, checking them against the model.
   task automatic service_begin(input int wait_n, output logic [CH-1:0] rt);
      int            code;
      logic [CH-1:0] exp_trig;
      repeat (wait_n) begin
         nstep();
         check("hold_note", note, pack_note());
         check("hold_gate", gate, m_gate);
         check("hold_trig", trig, 0);
         check("hold_bar", bar_start, 0);
      end
      rt       = '0;
      exp_trig = '0;
      for (int c = 0; c < CH; c++) begin
         code = int'(rom_mem[m_ptr][c*NB +: NB]);
         if (code == 1) begin
            m_gate[c] = 1'b0;
         end else if (code >= 2) begin
            m_note[c] = code;
            if (m_gate[c]) begin
               rt[c]     = 1'b1;
               m_gate[c] = 1'b0;
            end else begin
               m_gate[c]   = 1'b1;
               exp_trig[c] = 1'b1;
            end
         end
      end
      m_row = m_ptr;
      m_ptr = (m_ptr + 1) % ROWS;
      nstep();
      check("apply_note", note, pack_note());
      check("apply_gate", gate, m_gate);
      check("apply_trig", trig, exp_trig);
      check("apply_row", row, m_row);
      check("apply_bar", bar_start, (m_row % RPB) == 0);
      check("apply_addr", rom_addr, m_ptr);
   endtask

   // Retrigger gap: gates of rt stay low GAPN cycles, then rise with trig.
   task automatic service_gap(input logic [CH-1:0] rt);
      if (rt != '0) begin
         repeat (GAPN - 1) begin
            nstep();
            check("gap_gate", gate, m_gate);
            check("gap_trig", trig, 0);
         end
         nstep();
         m_gate = m_gate | rt;
         check("regate_gate", gate, m_gate);
         check("regate_trig", trig, rt);
      end
      nstep();
      check("post_trig", trig, 0);
      check("post_bar", bar_start, 0);
   endtask

   task automatic run_service(input int wait_n);
      logic [CH-1:0] rt;
      service_begin(wait_n, rt);
      service_gap(rt);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst  = 1'b1;
      run  = 1'b0;
      tick = 1'b0;
      model_reset();

      // Rows 0..4 are fixed; the rest of the loop is random.
      rom_mem[0] = DW'(60);
      rom_mem[1] = DW'(0);
      rom_mem[2] = DW'(1);
      rom_mem[3] = DW'(60);
      rom_mem[4] = DW'(62);
      for (int r = 5; r < ROWS; r++) rom_mem[r] = {rand_code(), rand_code(), rand_code()};

      repeat (3) @(negedge clk);
      check("rst_note", note, 0);
      check("rst_gate", gate, 0);
      check("rst_trig", trig, 0);
      check("rst_row", row, 0);
      check("rst_bar", bar_start, 0);
      check("rst_addr", rom_addr, 0);

      rst = 1'b0;
      run = 1'b1;
      repeat (2) nstep();

      // 33 ticks: full loop plus the wrap back to row 0.
      for (int t = 0; t < ROWS + 1; t++) begin
         tick = 1'b1;
         run_service(2);
         repeat ($urandom_range(0, 3)) nstep();
      end

      // Tick held high for 10 clocks advances exactly one row.
      tick = 1'b1;
      repeat (9) tick_sched.push_back(1'b1);
      run_service(2);
      while (tick_sched.size() > 0) nstep();
      repeat (4) nstep();
      check("hold10_row", row, m_row);
      check("hold10_addr", rom_addr, m_ptr);
      check("hold10_trig", trig, 0);

      // Ticks during a retrigger gap: the first is serviced right after the
      // gap, the second is dropped.
      p = m_ptr;
      rom_mem[p]              = DW'(70);
      rom_mem[(p + 1) % ROWS] = DW'(71);
      rom_mem[(p + 2) % ROWS] = DW'(1);
      tick = 1'b1;
      run_service(2);
      repeat (2) nstep();
      tick = 1'b1;
      tick_sched = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      service_begin(2, retr);
      service_gap(retr);
      run_service(1);
      repeat (12) nstep();
      check("drop_row", row, m_row);
      check("drop_addr", rom_addr, m_ptr);
      check("drop_gate", gate, m_gate);

      // run = 0 in the middle of a gap: gates drop, no trig, pointer rewinds.
      p = m_ptr;
      rom_mem[p]              = DW'(72);
      rom_mem[(p + 1) % ROWS] = DW'(73);
      tick = 1'b1;
      run_service(2);
      repeat (2) nstep();
      tick = 1'b1;
      service_begin(2, retr);
      nstep();
      run = 1'b0;
      nstep();
      m_gate = '0;
      m_ptr  = 0;
      check("stop_gate", gate, 0);
      check("stop_trig", trig, 0);
      check("stop_note", note, pack_note());
      check("stop_row", row, m_row);
      check("stop_addr", rom_addr, 0);
      tick_sched = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      repeat (8) begin
         nstep();
         check("stopped_gate", gate, 0);
         check("stopped_trig", trig, 0);
         check("stopped_row", row, m_row);
         check("stopped_addr", rom_addr, 0);
      end
      run = 1'b1;
      repeat (3) nstep();
      check("rerun_row", row, m_row);
      check("rerun_gate", gate, 0);
      check("rerun_addr", rom_addr, 0);
      tick = 1'b1;
      run_service(2);

      // Reset while a row is in flight.
      repeat (2) nstep();
      tick = 1'b1;
      nstep();
      nstep();
      rst = 1'b1;
      nstep();
      check("mrst_note", note, 0);
      check("mrst_gate", gate, 0);
      check("mrst_trig", trig, 0);
      check("mrst_row", row, 0);
      check("mrst_bar", bar_start, 0);
      check("mrst_addr", rom_addr, 0);
      rst = 1'b0;
      model_reset();
      repeat (2) nstep();
      tick = 1'b1;
      run_service(2);

      // ---------------------------------------------------------------- report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
